mxint8_block_loader: RTL and testbench

MXINT8_BLOCK_LOADER -- requirements
Module: mxint8_block_loader

---
 rtl/mxint8_block_loader_if.sv | 33 +++
 rtl/mxint8_block_loader.sv | 133 +++++++++++++
 tb/tb_mxint8_block_loader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mxint8_block_loader_if.sv
// Element-stream and block-presentation bus of the MXINT8 block loader.
// master = upstream producer / downstream consumer side, slave = the loader.
interface mxint8_block_loader_if #(
   parameter int BLOCK_SIZE           = 32,
   parameter int MXINT8_ELEMENT_WIDTH = 8,
   parameter int SCALE_WIDTH          = 8
);
   logic                                             elem_valid_i;
   logic                                             elem_ready_o;
   logic [MXINT8_ELEMENT_WIDTH-1:0]                  elem_data_i;
   logic                                             elem_last_i;
   logic [SCALE_WIDTH-1:0]                           scale_i;
   logic [0:BLOCK_SIZE-1][MXINT8_ELEMENT_WIDTH-1:0]  mxint8_elements_o;
   logic [SCALE_WIDTH-1:0]                           scale_o;
   logic                                             data_ready_o;
   logic                                             data_ack_i;
   logic                                             len_err_o;
   logic                                             scale_nan_o;
   // 1 while a block is presented (FSM in FULL)
   logic                                             dbg_full_o;

   modport master (
      output elem_valid_i, elem_data_i, elem_last_i, scale_i, data_ack_i,
      input  elem_ready_o, mxint8_elements_o, scale_o, data_ready_o,
             len_err_o, scale_nan_o, dbg_full_o
   );

   modport slave (
      input  elem_valid_i, elem_data_i, elem_last_i, scale_i, data_ack_i,
      output elem_ready_o, mxint8_elements_o, scale_o, data_ready_o,
             len_err_o, scale_nan_o, dbg_full_o
   );
endinterface

// File: rtl/mxint8_block_loader.sv
// Serial-to-parallel loader that assembles MXINT8 blocks (elements + E8M0 scale).
// Define MXINT8_LOADER_DBUF_EN to let a second block fill while one is presented.
//
// Handshakes: an element transfers on a rising edge where elem_valid_i=1 and
// elem_ready_o=1; a presented block is consumed on an edge where data_ready_o=1
// and data_ack_i=1 (data_ack_i is ignored while data_ready_o=0).
module mxint8_block_loader #(
   parameter int BLOCK_SIZE           = 32,
   parameter int MXINT8_ELEMENT_WIDTH = 8,
   parameter int SCALE_WIDTH          = 8
) (
   input logic                  clk,
   input logic                  rst,
   mxint8_block_loader_if.slave bus
);
   localparam int CNT_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

   typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

   typedef logic [0:BLOCK_SIZE-1][MXINT8_ELEMENT_WIDTH-1:0] block_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   block_t                 fill_q, fill_d;
   logic [SCALE_WIDTH-1:0] fill_scale_q, fill_scale_d;
   block_t                 out_q, out_d;
   logic [SCALE_WIDTH-1:0] out_scale_q, out_scale_d;
   logic                   len_err_q, len_err_d;
   logic                   nan_q, nan_d;
   logic                   hs, ack, done, last_idx;

`ifdef MXINT8_LOADER_DBUF_EN
   // The fill buffer doubles as the pending buffer once a block completes behind a presented one.
   logic pend_q, pend_d;
   assign bus.elem_ready_o = !rst && !(state_q == FULL && pend_q);
`else
   assign bus.elem_ready_o = !rst && (state_q == FILL);
`endif

   assign hs       = bus.elem_valid_i && bus.elem_ready_o;
   assign ack      = bus.data_ack_i && (state_q == FULL);
   assign last_idx = (cnt_q == CNT_W'(BLOCK_SIZE - 1));
   assign done     = hs && last_idx;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      fill_d       = fill_q;
      fill_scale_d = fill_scale_q;
      out_d        = out_q;
      out_scale_d  = out_scale_q;
      len_err_d    = 1'b0;
`ifdef MXINT8_LOADER_DBUF_EN
      pend_d       = pend_q;
`endif

      if (hs) begin
         fill_d[cnt_q] = bus.elem_data_i;
         if (cnt_q == '0) fill_scale_d = bus.scale_i;
         if (last_idx) begin
            cnt_d     = '0;
            len_err_d = !bus.elem_last_i;
         end else if (bus.elem_last_i) begin
            cnt_d     = '0;
            len_err_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      // Presenting always copies fill_d so a block finishing this cycle is taken whole.
      if (state_q == FILL) begin
         if (done) begin
            state_d     = FULL;
            out_d       = fill_d;
            out_scale_d = fill_scale_d;
         end
      end else begin
`ifdef MXINT8_LOADER_DBUF_EN
         if (ack) begin
            if (pend_q || done) begin
               out_d       = fill_d;
               out_scale_d = fill_scale_d;
               pend_d      = 1'b0;
            end else begin
               state_d = FILL;
            end
         end else if (done) begin
            pend_d = 1'b1;
         end
`else
         if (ack) state_d = FILL;
`endif
      end

      nan_d = (state_d == FULL) && (out_scale_d == {SCALE_WIDTH{1'b1}});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FILL;
         cnt_q        <= '0;
         fill_q       <= '0;
         fill_scale_q <= '0;
         out_q        <= '0;
         out_scale_q  <= '0;
         len_err_q    <= 1'b0;
         nan_q        <= 1'b0;
`ifdef MXINT8_LOADER_DBUF_EN
         pend_q       <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         fill_q       <= fill_d;
         fill_scale_q <= fill_scale_d;
         out_q        <= out_d;
         out_scale_q  <= out_scale_d;
         len_err_q    <= len_err_d;
         nan_q        <= nan_d;
`ifdef MXINT8_LOADER_DBUF_EN
         pend_q       <= pend_d;
`endif
      end
   end

   assign bus.mxint8_elements_o = out_q;
   assign bus.scale_o           = out_scale_q;
   assign bus.data_ready_o      = (state_q == FULL);
   assign bus.len_err_o         = len_err_q;
   assign bus.scale_nan_o       = nan_q;
   assign bus.dbg_full_o        = (state_q == FULL);
endmodule

// File: tb/tb_mxint8_block_loader.sv
// Directed bench for mxint8_block_loader: vector table plus hand-written corner sequences.
module tb_mxint8_block_loader;
   localparam int BS = 32;

`ifdef MXINT8_LOADER_DBUF_EN
   localparam logic EXP_RDY_FULL = 1'b1;
`else
   localparam logic EXP_RDY_FULL = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   logic [7:0] exp_q[$];
   logic [7:0] exp_blk[BS];

   typedef struct {
      logic [7:0] base;
      logic [7:0] step;
      logic [7:0] scale;
      logic       exp_nan;
   } vec_t;
   vec_t vecs[4];

   mxint8_block_loader_if #(.BLOCK_SIZE(BS), .MXINT8_ELEMENT_WIDTH(8), .SCALE_WIDTH(8)) bus ();

   mxint8_block_loader #(.BLOCK_SIZE(BS), .MXINT8_ELEMENT_WIDTH(8), .SCALE_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic send_elem(input logic [7:0] d, input logic l, input logic [7:0] s);
      int n = 0;
      @(negedge clk);
      bus.elem_valid_i = 1'b1;
      bus.elem_data_i  = d;
      bus.elem_last_i  = l;
      bus.scale_i      = s;
      while (!bus.elem_ready_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("elem_ready_timeout", 64'(bus.elem_ready_o), 64'd1);
   endtask

   // Sends n elements base+i*step; scale valid only on element 0, junk elsewhere.
   task automatic send_block(input logic [7:0] base, input logic [7:0] step,
                             input logic [7:0] scale, input int last_at, input int n);
      logic [7:0] d;
      for (int i = 0; i < n; i++) begin
         d = 8'(base + 8'(i) * step);
         exp_q.push_back(d);
         send_elem(d, (i == last_at), (i == 0) ? scale : ~scale);
      end
   endtask

   task automatic pop_block();
      for (int i = 0; i < BS; i++) exp_blk[i] = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
   endtask

   task automatic cmp_block(input string name);
      int bad = 0;
      for (int i = 0; i < BS; i++)
         if (bus.mxint8_elements_o[i] !== exp_blk[i]) bad++;
      chk(name, 64'(bad), 64'd0);
   endtask

   // Called at the negedge where the final element is driven.
   task automatic finish_block(input string name, input logic [7:0] scale,
                               input logic nan, input logic len_err);
      chk({name, "_dr_early"}, 64'(bus.data_ready_o), 64'd0);
      @(negedge clk);
      bus.elem_valid_i = 1'b0;
      bus.elem_last_i  = 1'b0;
      pop_block();
      chk({name, "_dr"}, 64'(bus.data_ready_o), 64'd1);
      chk({name, "_len_err"}, 64'(bus.len_err_o), 64'(len_err));
      chk({name, "_scale"}, 64'(bus.scale_o), 64'(scale));
      chk({name, "_nan"}, 64'(bus.scale_nan_o), 64'(nan));
      chk({name, "_ready"}, 64'(bus.elem_ready_o), 64'(EXP_RDY_FULL));
      cmp_block({name, "_elems"});
   endtask

   task automatic ack_block(input string name);
      bus.data_ack_i = 1'b1;
      @(negedge clk);
      bus.data_ack_i = 1'b0;
      chk({name, "_ack_dr"}, 64'(bus.data_ready_o), 64'd0);
      chk({name, "_ack_ready"}, 64'(bus.elem_ready_o), 64'd1);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_dr"}, 64'(bus.data_ready_o), 64'd0);
      chk({name, "_len_err"}, 64'(bus.len_err_o), 64'd0);
      chk({name, "_nan"}, 64'(bus.scale_nan_o), 64'd0);
      chk({name, "_scale"}, 64'(bus.scale_o), 64'd0);
      chk({name, "_elems_nz"}, 64'(bus.mxint8_elements_o != '0), 64'd0);
   endtask

   initial begin
      vecs[0] = '{base: 8'h00, step: 8'h01, scale: 8'h7F, exp_nan: 1'b0};
      vecs[1] = '{base: 8'h80, step: 8'h00, scale: 8'hFF, exp_nan: 1'b1};
      vecs[2] = '{base: 8'hFF, step: 8'hFF, scale: 8'h00, exp_nan: 1'b0};
      vecs[3] = '{base: 8'h55, step: 8'h33, scale: 8'hFE, exp_nan: 1'b0};

      bus.elem_valid_i = 1'b0;
      bus.elem_data_i  = '0;
      bus.elem_last_i  = 1'b0;
      bus.scale_i      = '0;
      bus.data_ack_i   = 1'b0;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      chk("reset_ready", 64'(bus.elem_ready_o), 64'd0);
      rst = 1'b0;
      #1;
      chk("ready_after_reset", 64'(bus.elem_ready_o), 64'd1);

      // Ack while nothing is presented must not disturb anything.
      @(negedge clk);
      bus.data_ack_i = 1'b1;
      @(negedge clk);
      bus.data_ack_i = 1'b0;
      chk("idle_ack_dr", 64'(bus.data_ready_o), 64'd0);
      chk("idle_ack_ready", 64'(bus.elem_ready_o), 64'd1);

      for (int v = 0; v < 4; v++) begin
         send_block(vecs[v].base, vecs[v].step, vecs[v].scale, BS - 1, BS);
         finish_block($sformatf("vec%0d", v), vecs[v].scale, vecs[v].exp_nan, 1'b0);
         if (v == 0) begin
            for (int c = 0; c < 10; c++) begin
               @(negedge clk);
               chk("hold_dr", 64'(bus.data_ready_o), 64'd1);
               chk("hold_ready", 64'(bus.elem_ready_o), 64'(EXP_RDY_FULL));
               chk("hold_scale", 64'(bus.scale_o), 64'h7F);
               cmp_block("hold_elems");
            end
         end
         ack_block($sformatf("vec%0d", v));
      end

      // Early last on index 5: one len_err pulse, nothing presented.
      send_block(8'h40, 8'h01, 8'h11, 5, 6);
      exp_q.delete();
      @(negedge clk);
      bus.elem_valid_i = 1'b0;
      bus.elem_last_i  = 1'b0;
      chk("short_len_err", 64'(bus.len_err_o), 64'd1);
      chk("short_dr", 64'(bus.data_ready_o), 64'd0);
      @(negedge clk);
      chk("short_len_err_drop", 64'(bus.len_err_o), 64'd0);
      chk("short_dr_later", 64'(bus.data_ready_o), 64'd0);
      send_block(8'h00, 8'h01, 8'h22, BS - 1, BS);
      finish_block("after_short", 8'h22, 1'b0, 1'b0);
      ack_block("after_short");

      // Missing last on index 31: block still presented, len_err alongside.
      send_block(8'h10, 8'h03, 8'h33, -1, BS);
      finish_block("no_last", 8'h33, 1'b0, 1'b1);
      @(negedge clk);
      chk("no_last_len_err_drop", 64'(bus.len_err_o), 64'd0);
      chk("no_last_dr_hold", 64'(bus.data_ready_o), 64'd1);
      ack_block("no_last");

      // Reset after 17 elements, then a clean block.
      send_block(8'h90, 8'h01, 8'h44, BS - 1, 17);
      exp_q.delete();
      @(negedge clk);
      bus.elem_valid_i = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero("mid_fill_rst");
      chk("mid_fill_rst_ready", 64'(bus.elem_ready_o), 64'd0);
      rst = 1'b0;
      send_block(8'hA0, 8'h01, 8'h01, BS - 1, BS);
      finish_block("post_rst", 8'h01, 1'b0, 1'b0);
      ack_block("post_rst");

      // Reset while a block is presented.
      send_block(8'h07, 8'h05, 8'hFF, BS - 1, BS);
      finish_block("pres", 8'hFF, 1'b1, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero("pres_rst");
      rst = 1'b0;

`ifdef MXINT8_LOADER_DBUF_EN
      // Second block fully loaded behind a presented one.
      send_block(8'h01, 8'h01, 8'h10, BS - 1, BS);
      finish_block("dbuf_a", 8'h10, 1'b0, 1'b0);
      send_block(8'h80, 8'h00, 8'hFF, BS - 1, BS);
      @(negedge clk);
      bus.elem_valid_i = 1'b0;
      bus.elem_last_i  = 1'b0;
      chk("dbuf_both_full_ready", 64'(bus.elem_ready_o), 64'd0);
      chk("dbuf_a_still_scale", 64'(bus.scale_o), 64'h10);
      chk("dbuf_a_still_dr", 64'(bus.data_ready_o), 64'd1);
      bus.data_ack_i = 1'b1;
      @(negedge clk);
      bus.data_ack_i = 1'b0;
      pop_block();
      chk("dbuf_b_dr", 64'(bus.data_ready_o), 64'd1);
      chk("dbuf_b_scale", 64'(bus.scale_o), 64'hFF);
      chk("dbuf_b_nan", 64'(bus.scale_nan_o), 64'd1);
      cmp_block("dbuf_b_elems");
      // Third block completes on the same edge as the ack of the second.
      send_block(8'h20, 8'h02, 8'h05, BS - 1, BS);
      bus.data_ack_i = 1'b1;
      @(negedge clk);
      bus.data_ack_i   = 1'b0;
      bus.elem_valid_i = 1'b0;
      bus.elem_last_i  = 1'b0;
      pop_block();
      chk("dbuf_c_dr", 64'(bus.data_ready_o), 64'd1);
      chk("dbuf_c_scale", 64'(bus.scale_o), 64'h05);
      chk("dbuf_c_nan", 64'(bus.scale_nan_o), 64'd0);
      cmp_block("dbuf_c_elems");
      ack_block("dbuf_c");
`endif

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
